register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp_if.sv | 31 +++
 rtl/register_file_mp.sv | 60 ++++++
 tb/tb_register_file_mp.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: write, read and clear signals of the multi-port register file; master drives requests, slave returns data and status
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              write_back_en;
  logic [ADDR_W-1:0] write_back_reg;
  logic [DATA_W-1:0] write_back;
  logic              write_back2_en;
  logic [ADDR_W-1:0] write_back2_reg;
  logic [DATA_W-1:0] write_back2;
  logic [ADDR_W-1:0] a_reg;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  modport master (
    output write_back_en, write_back_reg, write_back,
    output write_back2_en, write_back2_reg, write_back2,
    output a_reg, b_reg, clear_req,
    input  a, b, clear_busy, clear_done
  );
  modport slave (
    input  write_back_en, write_back_reg, write_back,
    input  write_back2_en, write_back2_reg, write_back2,
    input  a_reg, b_reg, clear_req,
    output a, b, clear_busy, clear_done
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: 2-write/2-read register file with optional zero register, write bypass and sequential clear; ports clk, rst (sync active-low), rf (slave: writes, reads, clear handshake)
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_busy, w_we0, w_we1, w_byp;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= (r_state == CLEAR) ? r_idx + ADDR_W'(1) : '0;
    end
  end
  always_comb
    w_next = (r_state == IDLE)  ? (rf.clear_req ? CLEAR : IDLE) :
             (r_state == CLEAR) ? ((r_idx == ADDR_W'(DEPTH - 1)) ? DONE : CLEAR) : IDLE;
  always_comb begin
    rf.clear_busy = (r_state == CLEAR);
    rf.clear_done = (r_state == DONE);
  end
  assign w_busy = (r_state == CLEAR);
  assign w_we0  = rf.write_back_en  && !(ZERO_REG != 0 && rf.write_back_reg  == '0);
  assign w_we1  = rf.write_back2_en && !(ZERO_REG != 0 && rf.write_back2_reg == '0);
  // bypass is also gated by reset so reads stay zero while rst is held low
  assign w_byp  = (BYPASS != 0) && rst && !w_busy;
  // port 1 is assigned last so it wins an address collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_busy) begin
      r_regs[r_idx] <= '0;
    end else begin
      if (w_we0) r_regs[rf.write_back_reg]  <= rf.write_back;
      if (w_we1) r_regs[rf.write_back2_reg] <= rf.write_back2;
    end
  end
  always_comb begin
    rf.a = (ZERO_REG != 0 && rf.a_reg == '0)             ? '0 :
           (w_byp && w_we1 && rf.write_back2_reg == rf.a_reg) ? rf.write_back2 :
           (w_byp && w_we0 && rf.write_back_reg  == rf.a_reg) ? rf.write_back :
           r_regs[rf.a_reg];
    rf.b = (ZERO_REG != 0 && rf.b_reg == '0)             ? '0 :
           (w_byp && w_we1 && rf.write_back2_reg == rf.b_reg) ? rf.write_back2 :
           (w_byp && w_we0 && rf.write_back_reg  == rf.b_reg) ? rf.write_back :
           r_regs[rf.b_reg];
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed self-checking bench for register_file_mp (default build plus a 16-bit/8-entry no-bypass build)
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  register_file_mp_if #(.DATA_W(32), .ADDR_W(5)) rf ();
  register_file_mp_if #(.DATA_W(16), .ADDR_W(3)) rf2 ();
  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (.clk(clk), .rst(rst), .rf(rf));
  register_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_dut2 (.clk(clk), .rst(rst), .rf(rf2));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    rf.write_back_en = 0; rf.write_back_reg = 0; rf.write_back = 0;
    rf.write_back2_en = 0; rf.write_back2_reg = 0; rf.write_back2 = 0;
    rf.a_reg = 0; rf.b_reg = 0; rf.clear_req = 0;
    rf2.write_back_en = 0; rf2.write_back_reg = 0; rf2.write_back = 0;
    rf2.write_back2_en = 0; rf2.write_back2_reg = 0; rf2.write_back2 = 0;
    rf2.a_reg = 0; rf2.b_reg = 0; rf2.clear_req = 0;
  endtask
  task automatic test_reset;
    rst = 0;
    step;
    rst = 1;
    step;
    checks++;
    if (rf.clear_busy !== 1'b0 || rf.clear_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy=%b done=%b expected 0 0", rf.clear_busy, rf.clear_done);
    end
    for (int i = 0; i < 32; i++) begin
      rf.a_reg = 5'(i); rf.b_reg = 5'(31 - i);
      #1;
      checks++;
      if (rf.a !== 32'h0 || rf.b !== 32'h0) begin
        failures++;
        $display("FAIL reset_read addr=%0d a=%h b=%h expected 0", i, rf.a, rf.b);
      end
    end
  endtask
  task automatic test_write_bypass;
    rf.write_back_en = 1; rf.write_back_reg = 5; rf.write_back = 32'h12345678;
    rf.a_reg = 5;
    #1;
    checks++;
    if (rf.a !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_p0 a=%h expected 12345678", rf.a);
    end
    step;
    rf.write_back_en = 0;
    #1;
    checks++;
    if (rf.a !== 32'h12345678) begin
      failures++;
      $display("FAIL stored_r5 a=%h expected 12345678", rf.a);
    end
    rf.write_back_en = 1; rf.write_back_reg = 9; rf.write_back = 32'h11111111;
    rf.write_back2_en = 1; rf.write_back2_reg = 9; rf.write_back2 = 32'h22222222;
    rf.b_reg = 9;
    #1;
    checks++;
    if (rf.b !== 32'h22222222) begin
      failures++;
      $display("FAIL bypass_priority b=%h expected 22222222", rf.b);
    end
    step;
    rf.write_back_en = 0; rf.write_back2_en = 0;
  endtask
  task automatic test_collision;
    rf.write_back_en = 1; rf.write_back_reg = 7; rf.write_back = 32'hAAAA0000;
    rf.write_back2_en = 1; rf.write_back2_reg = 7; rf.write_back2 = 32'h0000BBBB;
    step;
    rf.write_back_en = 0; rf.write_back2_en = 0;
    rf.b_reg = 7;
    #1;
    checks++;
    if (rf.b !== 32'h0000BBBB) begin
      failures++;
      $display("FAIL collision_r7 b=%h expected 0000bbbb", rf.b);
    end
    rf.write_back_en = 1; rf.write_back_reg = 0; rf.write_back = 32'hFFFFFFFF;
    rf.a_reg = 0;
    #1;
    checks++;
    if (rf.a !== 32'h0) begin
      failures++;
      $display("FAIL zero_bypass a=%h expected 0", rf.a);
    end
    step;
    rf.write_back_en = 0;
    #1;
    checks++;
    if (rf.a !== 32'h0) begin
      failures++;
      $display("FAIL zero_stored a=%h expected 0", rf.a);
    end
  endtask
  task automatic test_back_to_back;
    for (int i = 10; i < 14; i++) begin
      rf.write_back_en = 1; rf.write_back_reg = 5'(i); rf.write_back = 32'hC0DE0000 + 32'(i);
      step;
    end
    rf.write_back_en = 0;
    for (int i = 10; i < 14; i++) begin
      rf.a_reg = 5'(i); rf.b_reg = 5'(23 - i);
      #1;
      checks++;
      if (rf.a !== 32'hC0DE0000 + 32'(i) || rf.b !== 32'hC0DE0000 + 32'(23 - i)) begin
        failures++;
        $display("FAIL b2b_r%0d a=%h b=%h expected %h %h", i, rf.a, rf.b, 32'hC0DE0000 + 32'(i), 32'hC0DE0000 + 32'(23 - i));
      end
    end
  endtask
  task automatic test_clear;
    int busy_cnt;
    int done_cnt;
    for (int i = 1; i < 32; i++) begin
      rf.write_back_en = 1; rf.write_back_reg = 5'(i); rf.write_back = 32'(i);
      step;
    end
    rf.write_back_en = 0;
    rf.a_reg = 31; rf.b_reg = 17;
    #1;
    checks++;
    if (rf.a !== 32'd31 || rf.b !== 32'd17) begin
      failures++;
      $display("FAIL fill a=%h b=%h expected 1f 11", rf.a, rf.b);
    end
    rf.clear_req = 1;
    step;
    busy_cnt = 0;
    while (rf.clear_busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 2) rf.clear_req = 0;
      if (busy_cnt == 10) begin
        rf.write_back_en = 1; rf.write_back_reg = 3; rf.write_back = 32'h55; rf.a_reg = 3;
        #1;
        checks++;
        if (rf.a !== 32'h0) begin
          failures++;
          $display("FAIL busy_no_bypass a=%h expected 0", rf.a);
        end
      end
      if (busy_cnt == 11) rf.write_back_en = 0;
      step;
    end
    checks++;
    if (busy_cnt != 32) begin
      failures++;
      $display("FAIL clear_busy_len cycles=%0d expected 32", busy_cnt);
    end
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rf.clear_done === 1'b1) done_cnt++;
      checks++;
      if (i > 0 && rf.clear_busy !== 1'b0) begin
        failures++;
        $display("FAIL clear_requeue busy=%b expected 0", rf.clear_busy);
      end
      step;
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL clear_done_pulses count=%0d expected 1", done_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      rf.a_reg = 5'(i); rf.b_reg = 5'(i);
      #1;
      checks++;
      if (rf.a !== 32'h0 || rf.b !== 32'h0) begin
        failures++;
        $display("FAIL cleared_r%0d a=%h b=%h expected 0", i, rf.a, rf.b);
      end
    end
  endtask
  task automatic test_clear_abort;
    int busy_cnt;
    int done_cnt;
    rf.write_back_en = 1; rf.write_back_reg = 4; rf.write_back = 32'h44;
    rf.write_back2_en = 1; rf.write_back2_reg = 20; rf.write_back2 = 32'h20;
    step;
    rf.write_back_en = 0; rf.write_back2_en = 0;
    rf.clear_req = 1;
    step;
    rf.clear_req = 0;
    busy_cnt = 0;
    while (rf.clear_busy === 1'b1 && busy_cnt < 10) begin
      busy_cnt++;
      step;
    end
    checks++;
    if (busy_cnt != 10) begin
      failures++;
      $display("FAIL abort_busy_before cycles=%0d expected 10", busy_cnt);
    end
    rst = 0;
    step;
    checks++;
    if (rf.clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy busy=%b expected 0", rf.clear_busy);
    end
    rf.write_back_en = 1; rf.write_back_reg = 6; rf.write_back = 32'h66; rf.a_reg = 6; rf.b_reg = 20;
    #1;
    checks++;
    if (rf.a !== 32'h0 || rf.b !== 32'h0) begin
      failures++;
      $display("FAIL reset_held_read a=%h b=%h expected 0", rf.a, rf.b);
    end
    step;
    rst = 1;
    rf.write_back_en = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (rf.clear_done === 1'b1) done_cnt++;
      step;
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL abort_done pulses=%0d expected 0", done_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      rf.a_reg = 5'(i);
      #1;
      checks++;
      if (rf.a !== 32'h0) begin
        failures++;
        $display("FAIL abort_cleared_r%0d a=%h expected 0", i, rf.a);
      end
    end
  endtask
  task automatic test_sweep;
    int busy_cnt;
    rf2.write_back_en = 1; rf2.write_back_reg = 5; rf2.write_back = 16'h1234;
    step;
    rf2.write_back_en = 0;
    rf2.clear_req = 1;
    step;
    rf2.clear_req = 0;
    busy_cnt = 0;
    while (rf2.clear_busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      step;
    end
    checks++;
    if (busy_cnt != 8 || rf2.clear_done !== 1'b1) begin
      failures++;
      $display("FAIL sweep_clear_len cycles=%0d done=%b expected 8 1", busy_cnt, rf2.clear_done);
    end
    rf2.a_reg = 5;
    #1;
    checks++;
    if (rf2.a !== 16'h0) begin
      failures++;
      $display("FAIL sweep_cleared a=%h expected 0", rf2.a);
    end
    step;
    rf2.write_back_en = 1; rf2.write_back_reg = 2; rf2.write_back = 16'hBEEF; rf2.a_reg = 2;
    #1;
    checks++;
    if (rf2.a !== 16'h0) begin
      failures++;
      $display("FAIL sweep_no_bypass a=%h expected 0", rf2.a);
    end
    step;
    rf2.write_back_en = 0;
    #1;
    checks++;
    if (rf2.a !== 16'hBEEF) begin
      failures++;
      $display("FAIL sweep_after_edge a=%h expected beef", rf2.a);
    end
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_write_bypass();
    test_collision();
    test_back_to_back();
    test_clear();
    test_clear_abort();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
